reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Consumes the clock and PLL/MMCM lock status from the clock-management block and produces sequenced, synchronous-release resets for downstream logic. Lock is synchronised and filtered for stability, then STAGES reset outputs are released one after another at fixed intervals. A loss of lock or a soft-reset request re-asserts every stage at once. It sits directly after the clock generator and feeds the rst_n inputs of the design's functional blocks.

## Interface

- LOCK_STABLE_CYCLES, 1024: number of consecutive synchronised-lock-high cycles required before release; must be at least 1.
- STAGES, 3: number of reset outputs; allowed range 1..8.
- STAGE_GAP, 16: cycles between successive stage releases; must be at least 1.
- clock  in  1  the single clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state.
- pll_locked  in  1  asynchronous lock indication from the clock generator.
- soft_rst_req  in  1  synchronous single-cycle request to re-run the reset sequence.
- rst_n_out  out  STAGES  per-stage active-low reset; stage 0 releases first.
- sys_ready  out  1  high when all stages are released and the sequencer is in RUN.
- lock_loss_count  out  8  number of lock losses in RELEASE or RUN; saturates at 255.

## Operation

- pll_locked passes through a 2-flop synchroniser to give locked_s, with 2 cycles of latency.
- States:
  - HOLD: all rst_n_out=0, sys_ready=0, counter cleared.
  - STABLE: counts consecutive cycles with locked_s=1.
  - RELEASE: releases stages one at a time.
  - RUN: all stages released.
- HOLD -> STABLE when locked_s=1.
- STABLE:
  - locked_s=0 returns to HOLD and clears the counter. This is glitch filtering; it is not counted as a lock loss.
  - Moves to RELEASE when the count reaches LOCK_STABLE_CYCLES.
- RELEASE: rst_n_out[k] goes to 1 at k*STAGE_GAP cycles after rst_n_out[0]. Moves to RUN one cycle after the last stage releases.
- RUN: sys_ready=1; all outputs stay 1.
- Lock loss: locked_s=0 while in RELEASE or RUN.
  - Next state is HOLD.
  - All rst_n_out and sys_ready go to 0 on that same edge.
  - lock_loss_count increments by 1, saturating at 255.
- soft_rst_req=1 in STABLE, RELEASE or RUN goes to HOLD with all outputs cleared. It is ignored in HOLD. The full stability count is re-run.
- If soft_rst_req and a lock loss occur in the same cycle, the lock loss takes priority and is counted. The net effect is HOLD either way.
- Internal counter width is $clog2(max(LOCK_STABLE_CYCLES, (STAGES-1)*STAGE_GAP+1)+1). The counter never wraps: it is cleared on every state entry.
- rst_n_out bits are never released out of order. Once a stage is released, it is de-asserted only together with all other stages.

## Timing

- Reset values: rst_n_out=0, sys_ready=0, lock_loss_count=0, state=HOLD, synchroniser flops=0.
- rst assertion forces these values immediately (asynchronously), including mid-RELEASE. Release of rst takes effect at the next clock edge.
- Let edge E0 be the first edge at which locked_s=1 is sampled in HOLD. Then rst_n_out[0] rises at E0+1+LOCK_STABLE_CYCLES.
- rst_n_out[k] rises at E0+1+LOCK_STABLE_CYCLES+k*STAGE_GAP.
- sys_ready rises one cycle after rst_n_out[STAGES-1].
- From a pll_locked rising edge to rst_n_out[0], the delay is LOCK_STABLE_CYCLES+3 cycles, ±1 for synchroniser sampling.
- Lock-loss response: outputs fall 1 cycle after locked_s falls, which is 3 cycles after pll_locked falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Package clock_reset_pkg holds:
  - the state enum typedef seq_state_t (HOLD, STABLE, RELEASE, RUN);
  - the saturation constant LOSS_CNT_MAX=255.
- Sub-module sync_2ff is the parameterised-width 2-flop synchroniser used for pll_locked. It is reusable elsewhere in the clock-management tree.

## Test plan

All scenarios use LOCK_STABLE_CYCLES=8, STAGES=3, STAGE_GAP=4.

- Power-up: rst held 5 cycles, then pll_locked=1 steady. rst_n_out[0] rises 11 cycles after pll_locked, rst_n_out[1] 4 cycles later, rst_n_out[2] 4 cycles after that; sys_ready follows one cycle later; lock_loss_count=0.
- Lock glitch: pll_locked drops for 2 cycles during STABLE. All outputs stay 0, the count restarts from the re-lock, and lock_loss_count=0.
- Lock loss in RUN: pll_locked=0 for 1 cycle. All rst_n_out and sys_ready are 0 3 cycles later, lock_loss_count=1, and the full sequence re-runs after re-lock.
- Soft reset: soft_rst_req pulsed in RUN, then again mid-RELEASE. All outputs clear on the next edge each time; stages re-release in order 0,1,2; lock_loss_count is unchanged.
- Simultaneous events and saturation: soft_rst_req coincides with a lock loss, and lock is then toggled 300 times through RUN. Each loss is counted once and lock_loss_count stops at 255.
- Async reset mid-RELEASE, after stage 0 is released: all outputs are 0 immediately, without waiting for a clock edge, and lock_loss_count=0.

Source files
------------

// File: rtl/clock_reset_pkg.sv
// Shared types and constants for the clock/reset management tree.
// Holds the reset-sequencer state encoding and the lock-loss counter ceiling.
package clock_reset_pkg;

    typedef enum logic [1:0] {
        StHold,
        StStable,
        StRelease,
        StRun
    } seq_state_t;

    localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level signals, any width.
// Outputs follow the input with two cycles of latency; reset clears both stages.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_d, meta_q;
    logic [Width-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Filters PLL lock for stability, then releases STAGES active-low resets in order.
// Lock loss in RELEASE/RUN or a soft request drops every stage at once.
module reset_sequencer
    import clock_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGES             = 3,
    parameter int unsigned STAGE_GAP          = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
    output logic [STAGES-1:0] rst_n_out,
    output logic              sys_ready,
    output logic [7:0]        lock_loss_count
);

    // Count value in RELEASE at which RUN is entered, one past the last stage release.
    localparam int unsigned RelSpan = (STAGES - 1) * STAGE_GAP + 1;
    localparam int unsigned CntMax  = (LOCK_STABLE_CYCLES > RelSpan) ? LOCK_STABLE_CYCLES
                                                                      : RelSpan;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    logic              locked_s;
    seq_state_t        state_d, state_q;
    logic [CntW-1:0]   cnt_d, cnt_q;
    logic [STAGES-1:0] rst_n_d, rst_n_q;
    logic              sys_ready_d, sys_ready_q;
    logic [7:0]        loss_d, loss_q;
    logic [STAGES-1:0] rel_mask;
    logic              lock_lost;

    sync_2ff #(
        .Width(1)
    ) u_lock_sync (
        .clk_i(clock),
        .rst_i(rst),
        .d_i  (pll_locked),
        .q_o  (locked_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_n_d     = rst_n_q;
        sys_ready_d = sys_ready_q;
        loss_d      = loss_q;
        rel_mask    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            rel_mask[k] = (cnt_q == CntW'(k * STAGE_GAP));
        end
        lock_lost = ((state_q == StRelease) || (state_q == StRun)) && !locked_s;

        case (state_q)
            StHold: begin
                rst_n_d     = '0;
                sys_ready_d = 1'b0;
                cnt_d       = '0;
                if (locked_s) begin
                    state_d = StStable;
                end
            end
            StStable: begin
                // A drop here is a glitch: restart filtering without counting a loss.
                if (!locked_s) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                rst_n_d = rst_n_q | rel_mask;
                if (cnt_q == CntW'(RelSpan)) begin
                    state_d     = StRun;
                    sys_ready_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                sys_ready_d = 1'b1;
            end
            default: begin
                state_d = StHold;
            end
        endcase

        if (lock_lost || (soft_rst_req && (state_q != StHold))) begin
            state_d     = StHold;
            cnt_d       = '0;
            rst_n_d     = '0;
            sys_ready_d = 1'b0;
            if (lock_lost && (loss_q != LOSS_CNT_MAX)) begin
                loss_d = loss_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            rst_n_q     <= '0;
            sys_ready_q <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_n_q     <= rst_n_d;
            sys_ready_q <= sys_ready_d;
            loss_q      <= loss_d;
        end
    end

    assign rst_n_out       = rst_n_q;
    assign sys_ready       = sys_ready_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (LOCK_STABLE_CYCLES=8, STAGES=3, STAGE_GAP=4).
// Expected {sys_ready, rst_n_out, lock_loss_count} values are queued by cycle and checked on negedges.
module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       soft_rst_req;
    logic [2:0] rst_n_out;
    logic       sys_ready;
    logic [7:0] lock_loss_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .STAGES            (3),
        .STAGE_GAP         (4)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_rst_req   (soft_rst_req),
        .rst_n_out      (rst_n_out),
        .sys_ready      (sys_ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] obs();
        return {20'd0, sys_ready, rst_n_out, lock_loss_count};
    endfunction

    function automatic logic [31:0] pack(logic sr, logic [2:0] rn, logic [7:0] lc);
        return {20'd0, sr, rn, lc};
    endfunction

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic push_exp(int c, logic sr, logic [2:0] rn, logic [7:0] lc, string tag);
        exp_t e;
        int   pos;
        e.cyc = c;
        e.val = pack(sr, rn, lc);
        e.tag = tag;
        pos   = sbq.size();
        while (pos > 0 && sbq[pos-1].cyc > c) pos--;
        sbq.insert(pos, e);
    endtask

    // Full release sequence whose stage 0 is first seen high at cycle r0.
    task automatic push_seq(int r0, logic [7:0] lc, string tag);
        push_exp(r0 - 1, 1'b0, 3'b000, lc, {tag, "_pre"});
        push_exp(r0,     1'b0, 3'b001, lc, {tag, "_s0"});
        push_exp(r0 + 3, 1'b0, 3'b001, lc, {tag, "_s0_hold"});
        push_exp(r0 + 4, 1'b0, 3'b011, lc, {tag, "_s1"});
        push_exp(r0 + 7, 1'b0, 3'b011, lc, {tag, "_s1_hold"});
        push_exp(r0 + 8, 1'b0, 3'b111, lc, {tag, "_s2"});
        push_exp(r0 + 9, 1'b1, 3'b111, lc, {tag, "_ready"});
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clock);
    endtask

    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            check(mon_e.tag, obs(), mon_e.val);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int lc;
        rst          = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        repeat (5) @(negedge clock);
        check("reset_state", obs(), pack(1'b0, 3'b000, 8'd0));
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // Power-up: stage 0 first seen 12 negedges after the drive point (11 edges after sampling).
        c          = cyc;
        pll_locked = 1'b1;
        push_seq(c + 12, 8'd0, "pwr");
        wait_until(c + 25);

        // Soft reset in RUN, then a 2-cycle lock glitch during STABLE.
        c            = cyc;
        soft_rst_req = 1'b1;
        push_exp(c + 1, 1'b0, 3'b000, 8'd0, "soft_run_clr");
        push_exp(c + 11, 1'b0, 3'b000, 8'd0, "glitch_no_release");
        @(negedge clock);
        soft_rst_req = 1'b0;
        wait_until(c + 5);
        pll_locked = 1'b0;
        wait_until(c + 7);
        pll_locked = 1'b1;
        push_seq(c + 19, 8'd0, "glitch");
        wait_until(c + 30);

        // Soft reset in RUN, then again just after stage 0 releases.
        c            = cyc;
        soft_rst_req = 1'b1;
        push_exp(c + 1, 1'b0, 3'b000, 8'd0, "soft2_clr");
        push_exp(c + 10, 1'b0, 3'b000, 8'd0, "soft2_pre");
        push_exp(c + 11, 1'b0, 3'b001, 8'd0, "soft2_s0");
        push_exp(c + 12, 1'b0, 3'b001, 8'd0, "soft2_s0_hold");
        @(negedge clock);
        soft_rst_req = 1'b0;
        wait_until(c + 12);
        soft_rst_req = 1'b1;
        push_exp(c + 13, 1'b0, 3'b000, 8'd0, "soft_rel_clr");
        push_seq(c + 23, 8'd0, "soft_rel");
        @(negedge clock);
        soft_rst_req = 1'b0;
        wait_until(c + 33);

        // One-cycle lock loss in RUN.
        c          = cyc;
        pll_locked = 1'b0;
        push_exp(c + 2, 1'b1, 3'b111, 8'd0, "pre_loss");
        push_exp(c + 3, 1'b0, 3'b000, 8'd1, "loss_clr");
        @(negedge clock);
        pll_locked = 1'b1;
        push_seq(c + 13, 8'd1, "relock");
        wait_until(c + 23);

        // Soft request on the same edge that sees the lock loss: counted once.
        c          = cyc;
        pll_locked = 1'b0;
        push_exp(c + 2, 1'b1, 3'b111, 8'd1, "pre_simul");
        push_exp(c + 3, 1'b0, 3'b000, 8'd2, "simul_clr");
        @(negedge clock);
        pll_locked = 1'b1;
        @(negedge clock);
        soft_rst_req = 1'b1;
        @(negedge clock);
        soft_rst_req = 1'b0;
        push_seq(c + 13, 8'd2, "simul");
        wait_until(c + 23);

        // 300 losses through RUN; the counter must stick at 255.
        lc = 2;
        for (int i = 0; i < 300; i++) begin
            c          = cyc;
            lc         = (lc == 255) ? 255 : lc + 1;
            pll_locked = 1'b0;
            push_exp(c + 3, 1'b0, 3'b000, 8'(lc), "sat_clr");
            @(negedge clock);
            pll_locked = 1'b1;
            push_exp(c + 22, 1'b1, 3'b111, 8'(lc), "sat_ready");
            wait_until(c + 23);
        end
        check("sat_final", {24'd0, lock_loss_count}, 32'd255);

        // Asynchronous reset between stage 0 and stage 1 releases.
        c            = cyc;
        soft_rst_req = 1'b1;
        push_exp(c + 1, 1'b0, 3'b000, 8'd255, "pre_async_clr");
        push_exp(c + 11, 1'b0, 3'b001, 8'd255, "pre_async_s0");
        @(negedge clock);
        soft_rst_req = 1'b0;
        wait_until(c + 12);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", obs(), pack(1'b0, 3'b000, 8'd0));
        @(negedge clock);
        check("rst_hold", obs(), pack(1'b0, 3'b000, 8'd0));
        rst = 1'b0;
        repeat (2) @(negedge clock);
        check("post_rst", obs(), pack(1'b0, 3'b000, 8'd0));

        check("sb_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
